// File: rtl/i2s_clk_monitor_apb_if.sv
// APB slave bundle for the I2S clock monitor.
// Zero-wait-state bus: pready simply mirrors penable.
interface i2s_clk_monitor_apb_if;
  logic [4:0]  paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  modport master (
    output paddr,
    output psel,
    output penable,
    output pwrite,
    output pwdata,
    input  prdata,
    input  pready
  );

  modport slave (
    input  paddr,
    input  psel,
    input  penable,
    input  pwrite,
    input  pwdata,
    output prdata,
    output pready
  );
endinterface

// File: rtl/i2s_clk_monitor_apb.sv
// Measures external bclk/lrclk in the clk domain and tracks lock.
// Sticky lost/timeout flags drive irq; all state is APB visible.
module i2s_clk_monitor_apb #(
  parameter int unsigned      CNT_W       = 20,
  parameter int unsigned      TOL         = 4,
  parameter int unsigned      LOCK_FRAMES = 4,
  parameter logic [CNT_W-1:0] TIMEOUT     = 20'hFFFFF
) (
  input  logic                  clk,
  input  logic                  reset,
  i2s_clk_monitor_apb_if.slave  apb,
  input  logic                  ext_bclk,
  input  logic                  ext_lrclk,
  output logic                  locked,
  output logic                  irq
);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_e;

  localparam int unsigned      MW      = $clog2(LOCK_FRAMES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] TMO_M1  = TIMEOUT - CNT_ONE;
  localparam logic [MW-1:0]    LOCK_C  = MW'(LOCK_FRAMES);

  state_e state_q;
  state_e state_d;

  logic [2:0] bsync_q;
  logic [2:0] lsync_q;
  logic       b_rise;
  logic       l_rise;

  logic [9:0] bclk_cnt_q;
  logic [9:0] bclk_cnt_d;
  logic [9:0] bclk_pf_q;
  logic [9:0] bclk_pf_d;
  logic [9:0] ref_bclk_q;
  logic [9:0] ref_bclk_d;

  logic [CNT_W-1:0] clk_cnt_q;
  logic [CNT_W-1:0] clk_cnt_d;
  logic [CNT_W-1:0] clk_pf_q;
  logic [CNT_W-1:0] clk_pf_d;
  logic [CNT_W-1:0] ref_clk_q;
  logic [CNT_W-1:0] ref_clk_d;

  logic          has_ref_q;
  logic          has_ref_d;
  logic [MW-1:0] match_q;
  logic [MW-1:0] match_d;
  logic [MW-1:0] match_inc;

  logic en_q;
  logic en_d;
  logic irqen_q;
  logic irqen_d;
  logic lost_q;
  logic lost_d;
  logic tmo_q;
  logic tmo_d;

  logic [31:0] prdata_q;
  logic [31:0] prdata_d;
  logic [31:0] rdata;

  logic [9:0]       bclk_inc;
  logic [9:0]       bclk_start;
  logic [CNT_W-1:0] clk_inc;
  logic [CNT_W-1:0] meas_clk;
  logic [CNT_W-1:0] delta;
  logic             meas_ok;
  logic             tmo_hit;
  logic             capture;
  logic             set_lost;
  logic             set_tmo;

  logic wr_en;
  logic rd_setup;
  logic sel_ctrl;
  logic sel_stat;
  logic sel_bpf;
  logic sel_cpf;
  logic unused_wdata;

  // Third flop of each chain is the previous sample for edge detect
  assign b_rise = bsync_q[1] & ~bsync_q[2];
  assign l_rise = lsync_q[1] & ~lsync_q[2];

  assign bclk_start = b_rise ? 10'd1 : 10'd0;
  assign bclk_inc   = (b_rise && bclk_cnt_q != 10'h3FF)
                    ? bclk_cnt_q + 10'd1 : bclk_cnt_q;
  assign clk_inc    = (&clk_cnt_q) ? clk_cnt_q : clk_cnt_q + CNT_ONE;
  assign meas_clk   = clk_inc;

  assign delta   = (meas_clk >= ref_clk_q)
                 ? meas_clk - ref_clk_q : ref_clk_q - meas_clk;
  assign meas_ok = has_ref_q
                 && (bclk_cnt_q == ref_bclk_q)
                 && (delta <= TOL_C);
  assign tmo_hit   = clk_cnt_q >= TMO_M1;
  assign match_inc = match_q + MW'(1);

  always_comb begin
    state_d    = state_q;
    bclk_cnt_d = bclk_cnt_q;
    clk_cnt_d  = clk_cnt_q;
    ref_bclk_d = ref_bclk_q;
    ref_clk_d  = ref_clk_q;
    has_ref_d  = has_ref_q;
    match_d    = match_q;
    capture    = 1'b0;
    set_lost   = 1'b0;
    set_tmo    = 1'b0;
    unique case (state_q)
      IDLE: begin
        bclk_cnt_d = '0;
        clk_cnt_d  = '0;
        if (en_q && l_rise) begin
          state_d    = ACQUIRE;
          bclk_cnt_d = bclk_start;
        end
      end
      ACQUIRE, LOCKED: begin
        bclk_cnt_d = bclk_inc;
        clk_cnt_d  = clk_inc;
        if (l_rise) begin
          capture    = 1'b1;
          bclk_cnt_d = bclk_start;
          clk_cnt_d  = '0;
          if (state_q == LOCKED) begin
            if (!meas_ok) begin
              state_d   = ACQUIRE;
              has_ref_d = 1'b0;
              match_d   = '0;
              set_lost  = 1'b1;
            end
          end else begin
            ref_bclk_d = bclk_cnt_q;
            ref_clk_d  = meas_clk;
            has_ref_d  = 1'b1;
            if (meas_ok) begin
              match_d = match_inc;
              if (match_inc == LOCK_C) state_d = LOCKED;
            end else begin
              match_d = '0;
            end
          end
        end else if (tmo_hit) begin
          state_d    = IDLE;
          set_tmo    = 1'b1;
          bclk_cnt_d = '0;
          clk_cnt_d  = '0;
          has_ref_d  = 1'b0;
          match_d    = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    // Disable overrides everything except sticky flags and last readings
    if (!en_q) begin
      state_d    = IDLE;
      bclk_cnt_d = '0;
      clk_cnt_d  = '0;
      has_ref_d  = 1'b0;
      match_d    = '0;
      capture    = 1'b0;
      set_lost   = 1'b0;
      set_tmo    = 1'b0;
    end
  end

  assign wr_en    = apb.psel & apb.pwrite & apb.penable;
  assign rd_setup = apb.psel & ~apb.pwrite & ~apb.penable;
  assign sel_ctrl = apb.paddr == 5'h00;
  assign sel_stat = apb.paddr == 5'h04;
  assign sel_bpf  = apb.paddr == 5'h08;
  assign sel_cpf  = apb.paddr == 5'h0C;

  assign unused_wdata = ^apb.pwdata[31:3];

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_ctrl: rdata = {30'd0, irqen_q, en_q};
      sel_stat: rdata = {29'd0, tmo_q, lost_q, locked};
      sel_bpf:  rdata = {22'd0, bclk_pf_q};
      sel_cpf:  rdata = 32'(clk_pf_q);
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    en_d      = (wr_en && sel_ctrl) ? apb.pwdata[0] : en_q;
    irqen_d   = (wr_en && sel_ctrl) ? apb.pwdata[1] : irqen_q;
    lost_d    = set_lost
              | (lost_q & ~(wr_en & sel_stat & apb.pwdata[1]));
    tmo_d     = set_tmo
              | (tmo_q & ~(wr_en & sel_stat & apb.pwdata[2]));
    bclk_pf_d = capture ? bclk_cnt_q : bclk_pf_q;
    clk_pf_d  = capture ? meas_clk : clk_pf_q;
    prdata_d  = rd_setup ? rdata : prdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bsync_q    <= '0;
      lsync_q    <= '0;
      bclk_cnt_q <= '0;
      clk_cnt_q  <= '0;
      bclk_pf_q  <= '0;
      clk_pf_q   <= '0;
      ref_bclk_q <= '0;
      ref_clk_q  <= '0;
      has_ref_q  <= 1'b0;
      match_q    <= '0;
      en_q       <= 1'b0;
      irqen_q    <= 1'b0;
      lost_q     <= 1'b0;
      tmo_q      <= 1'b0;
      prdata_q   <= '0;
    end else begin
      state_q    <= state_d;
      bsync_q    <= {bsync_q[1:0], ext_bclk};
      lsync_q    <= {lsync_q[1:0], ext_lrclk};
      bclk_cnt_q <= bclk_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      bclk_pf_q  <= bclk_pf_d;
      clk_pf_q   <= clk_pf_d;
      ref_bclk_q <= ref_bclk_d;
      ref_clk_q  <= ref_clk_d;
      has_ref_q  <= has_ref_d;
      match_q    <= match_d;
      en_q       <= en_d;
      irqen_q    <= irqen_d;
      lost_q     <= lost_d;
      tmo_q      <= tmo_d;
      prdata_q   <= prdata_d;
    end
  end

  assign apb.prdata = prdata_q;
  assign apb.pready = apb.penable;
  assign locked     = state_q == LOCKED;
  assign irq        = irqen_q & (lost_q | tmo_q);

endmodule

// File: tb/tb_i2s_clk_monitor_apb.sv
// Bench for i2s_clk_monitor_apb: frame table with scoreboard queue,
// plus timeout, disable and reset sequences.
module tb_i2s_clk_monitor_apb;

  localparam int TMO = 2000;

  typedef struct {
    int          len;
    int          ph;
    logic [9:0]  bpf;
    logic [19:0] cpf;
    logic [2:0]  st;
    logic        lk;
    logic        iq;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic bclk = 1'b0;
  logic lrclk = 1'b0;
  logic locked;
  logic irq;

  i2s_clk_monitor_apb_if apb ();

  i2s_clk_monitor_apb #(
    .TIMEOUT (20'(TMO))
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .apb       (apb),
    .ext_bclk  (bclk),
    .ext_lrclk (lrclk),
    .locked    (locked),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;
  int unsigned t_rise = 0;
  vec_t tbl[16];
  vec_t sb[$];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    apb.paddr   = a;
    apb.pwdata  = d;
    apb.pwrite  = 1'b1;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    @(negedge clk);
    apb.penable = 1'b1;
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
    apb.pwrite  = 1'b0;
  endtask

  task automatic read_chk(input string nm, input logic [4:0] a,
                          input logic [31:0] exp);
    @(negedge clk);
    apb.paddr   = a;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    #1;
    check({nm, " pready_setup"}, 32'(apb.pready), 32'd0);
    @(negedge clk);
    apb.penable = 1'b1;
    #1;
    check({nm, " pready"}, 32'(apb.pready), 32'd1);
    check(nm, apb.prdata, exp);
    @(negedge clk);
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  // One frame: lrclk high for the first half, up to 64 bclk pulses
  // of period 8 starting ph cycles after the frame edge.
  task automatic drive_frame(input int len, input int ph);
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      if (c == 0) t_rise = cyc;
      lrclk = (c < len / 2);
      bclk  = (c >= ph) && (c - ph < 512) && ((c - ph) % 8 < 4);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    apb.paddr   = '0;
    apb.pwdata  = '0;
    apb.pwrite  = 1'b0;
    apb.psel    = 1'b0;
    apb.penable = 1'b0;

    tbl[0]  = '{512, 4,  0,   0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{512, 4, 64, 512, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{512, 4, 64, 512, 3'd0, 1'b0, 1'b0};
    tbl[3]  = '{512, 4, 64, 512, 3'd0, 1'b0, 1'b0};
    tbl[4]  = '{512, 4, 64, 512, 3'd0, 1'b0, 1'b0};
    tbl[5]  = '{512, 4, 64, 512, 3'd1, 1'b1, 1'b0};
    tbl[6]  = '{514, 4, 64, 512, 3'd1, 1'b1, 1'b0};
    tbl[7]  = '{512, 4, 64, 514, 3'd1, 1'b1, 1'b0};
    tbl[8]  = '{520, 4, 64, 512, 3'd1, 1'b1, 1'b0};
    tbl[9]  = '{512, 0, 64, 520, 3'd2, 1'b0, 1'b1};
    tbl[10] = '{512, 0, 64, 512, 3'd2, 1'b0, 1'b1};
    tbl[11] = '{512, 0, 64, 512, 3'd2, 1'b0, 1'b1};
    tbl[12] = '{512, 0, 64, 512, 3'd2, 1'b0, 1'b1};
    tbl[13] = '{512, 0, 64, 512, 3'd2, 1'b0, 1'b1};
    tbl[14] = '{512, 0, 64, 512, 3'd3, 1'b1, 1'b1};
    tbl[15] = '{512, 0, 64, 512, 3'd3, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset locked", 32'(locked), 32'd0);
    check("reset irq", 32'(irq), 32'd0);
    check("reset prdata", apb.prdata, 32'd0);
    read_chk("reset status", 5'h04, 32'd0);
    read_chk("reset clk_pf", 5'h0C, 32'd0);

    apb_write(5'h00, 32'h3);
    read_chk("ctrl rd", 5'h00, 32'h3);

    for (int i = 0; i < 16; i++) begin
      sb.push_back(tbl[i]);
      fork
        drive_frame(tbl[i].len, tbl[i].ph);
        begin
          repeat (16) @(negedge clk);
          e = sb.pop_front();
          read_chk($sformatf("row%0d bclk_pf", i), 5'h08, 32'(e.bpf));
          read_chk($sformatf("row%0d clk_pf", i), 5'h0C, 32'(e.cpf));
          read_chk($sformatf("row%0d status", i), 5'h04, 32'(e.st));
          check($sformatf("row%0d locked", i), 32'(locked), 32'(e.lk));
          check($sformatf("row%0d irq", i), 32'(irq), 32'(e.iq));
        end
      join
    end

    @(negedge clk);
    bclk  = 1'b0;
    lrclk = 1'b0;
    apb_write(5'h08, 32'h3FF);
    read_chk("ro bclk_pf", 5'h08, 32'd64);
    read_chk("unmapped", 5'h10, 32'd0);
    apb_write(5'h04, 32'h2);
    read_chk("lost clr status", 5'h04, 32'h1);
    check("lost clr irq", 32'(irq), 32'd0);

    while (cyc < t_rise + 2 + TMO) @(negedge clk);
    check("pre tmo locked", 32'(locked), 32'd1);
    check("pre tmo irq", 32'(irq), 32'd0);
    @(negedge clk);
    check("tmo locked", 32'(locked), 32'd0);
    check("tmo irq", 32'(irq), 32'd1);
    read_chk("tmo status", 5'h04, 32'h4);

    fork
      drive_frame(512, 4);
      begin
        repeat (16) @(negedge clk);
        apb_write(5'h00, 32'h2);
        check("dis locked", 32'(locked), 32'd0);
      end
    join
    drive_frame(400, 4);
    drive_frame(400, 4);
    read_chk("dis status", 5'h04, 32'h4);
    check("dis irq", 32'(irq), 32'd1);
    read_chk("dis bclk_pf", 5'h08, 32'd64);
    read_chk("dis clk_pf", 5'h0C, 32'd512);
    read_chk("dis ctrl", 5'h00, 32'h2);

    apb_write(5'h00, 32'h3);
    fork
      drive_frame(400, 4);
      begin
        repeat (16) @(negedge clk);
        read_chk("reen first clk_pf", 5'h0C, 32'd512);
      end
    join
    fork
      drive_frame(400, 4);
      begin
        repeat (16) @(negedge clk);
        read_chk("reen bclk_pf", 5'h08, 32'd50);
        read_chk("reen clk_pf", 5'h0C, 32'd400);
        apb_write(5'h04, 32'h4);
        check("tmo clr irq", 32'(irq), 32'd0);
        read_chk("tmo clr status", 5'h04, 32'd0);
      end
    join
    drive_frame(400, 4);
    drive_frame(400, 4);
    drive_frame(400, 4);
    fork
      drive_frame(400, 4);
      begin
        repeat (16) @(negedge clk);
        check("relock locked", 32'(locked), 32'd1);
        read_chk("relock status", 5'h04, 32'h1);
        read_chk("relock clk_pf", 5'h0C, 32'd400);
      end
    join

    @(negedge clk);
    bclk  = 1'b0;
    lrclk = 1'b0;
    check("pre rst locked", 32'(locked), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst locked", 32'(locked), 32'd0);
    check("rst irq", 32'(irq), 32'd0);
    check("rst prdata", apb.prdata, 32'd0);
    read_chk("rst ctrl", 5'h00, 32'd0);
    read_chk("rst status", 5'h04, 32'd0);
    read_chk("rst bclk_pf", 5'h08, 32'd0);
    read_chk("rst clk_pf", 5'h0C, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/i2s_clk_monitor_apb.md
Name: i2s_clk_monitor_apb

Overview:
- Slave-mode companion to the I2S clock controller. It measures externally supplied bclk and lrclk in the clk domain.
- Reports bclk edges per frame and clk cycles per frame, and runs a lock state machine.
- Flags loss of lock and clock timeout through sticky status bits and an interrupt.
- Software reads it over APB to choose clock setup and check the external master before enabling streaming.

Parameters:
CNT_W, 20, width of the clk-cycles-per-frame counter.
TOL, 4, max allowed |delta| in clk cycles between frame periods that still counts as a match.
LOCK_FRAMES, 4, consecutive matching frames needed to declare lock.
TIMEOUT, 20'hFFFFF, clk cycles without an lrclk rising edge before a timeout fires.

Ports:
clk  in  1  interface clock; all logic runs on it
reset  in  1  synchronous, active-high
paddr  in  5  APB address
psel  in  1  APB select
penable  in  1  APB enable
pwrite  in  1  APB write strobe
pwdata  in  32  APB write data
prdata  out  32  APB read data, registered
pready  out  1  equal to penable; no wait states
ext_bclk  in  1  external bit clock, asynchronous to clk
ext_lrclk  in  1  external frame clock, asynchronous to clk
locked  out  1  high while the FSM is in LOCKED
irq  out  1  equals CTRL.irq_en & (STATUS.lost | STATUS.timeout)

Behaviour:
Reset:
- All registers, counters, prdata, locked and irq go to 0.
- FSM goes to IDLE.

Input synchronisation and edge detect:
- Each external input passes through a 2-flop synchroniser, then a third flop for edge detect.
- A rise is detected 3 clk cycles after the pin changes.
- Only rising edges are used.

Register map (byte addresses):
- 0x00 CTRL, R/W: bit0 enable, bit1 irq_en.
- 0x04 STATUS: bit0 locked (RO), bit1 lost (sticky, W1C), bit2 timeout (sticky, W1C).
- 0x08 BCLK_PF, RO: [9:0] bclk rises in the last frame.
- 0x0C CLK_PF, RO: [CNT_W-1:0] clk cycles in the last frame.
- Unmapped reads return 0. Writes to RO or unmapped addresses are ignored.

APB protocol:
- Write commits when psel & pwrite & penable.
- prdata loads in the setup phase (psel & ~pwrite & ~penable) and holds until the next read.
- If a W1C clear and a set event occur in the same cycle, the set wins.

Counting:
- bclk_cnt (10 bit) increments on each bclk rise and saturates at 1023.
- clk_cnt (CNT_W bit) increments every cycle and saturates at all-ones.
- On an lrclk rise: BCLK_PF <= bclk_cnt, CLK_PF <= clk_cnt+1, clk_cnt <= 0, bclk_cnt <= (bclk rise this cycle ? 1 : 0).
- A bclk edge coincident with the lrclk edge therefore belongs to the new frame.
- BCLK_PF and CLK_PF update only in ACQUIRE and LOCKED.

FSM states: IDLE, ACQUIRE, LOCKED.
- IDLE:
  - Counters are held at 0.
  - When enable=1, the first lrclk rise moves to ACQUIRE and restarts the counters. No measurement is captured on that edge.
- ACQUIRE:
  - Each lrclk rise produces a measurement.
  - With no reference yet, the measurement is stored as the reference and match_cnt=0.
  - Otherwise a match is bclk equal AND |clk - ref_clk| <= TOL.
  - On a match, match_cnt++; on a mismatch, the reference is replaced and match_cnt=0.
  - The reference is updated to the latest measurement in both cases.
  - When match_cnt reaches LOCK_FRAMES, go to LOCKED and set locked=1 on the next cycle.
- LOCKED:
  - Measurements are compared against the reference frozen at lock.
  - A mismatch moves to ACQUIRE, clears the reference, sets lost, and drops locked.
- Timeout: in ACQUIRE or LOCKED, if clk_cnt reaches TIMEOUT without an lrclk rise, go to IDLE, set timeout, and drop locked.
- Disable: enable=0 forces IDLE on the next cycle and clears counters, reference and match_cnt. Sticky bits and BCLK_PF/CLK_PF are retained.
- Enabling while ext_lrclk is static yields a timeout after the first lrclk rise plus TIMEOUT cycles. With no rise at all, the block stays in IDLE and no timeout occurs.

Test Plan:
- Enable; drive lrclk period 512 clk with bclk period 8 clk (64 bclk/frame). Required: locked rises 1 cycle after the 6th synced lrclk rise; BCLK_PF=64; CLK_PF=512; irq=0.
- While locked, jitter one frame to 514 clk (within TOL=4). Required: locked stays 1; CLK_PF=514. Then a 520-clk frame: locked drops, STATUS=0x2, irq=1 if irq_en=1.
- Stop lrclk while locked. Required: exactly TIMEOUT cycles after the last rise, FSM goes to IDLE, STATUS.timeout=1, locked=0. Writing 0x4 to STATUS clears timeout and irq falls.
- Place a bclk rise on the same cycle as an lrclk rise. Required: that bclk edge counts in the next frame's BCLK_PF (64, not 65) and lock holds.
- Clear enable mid-ACQUIRE, then assert reset mid-LOCKED. Required: disable → IDLE next cycle, sticky bits kept. Reset → all registers 0, prdata=0, locked=0.
- APB: write CTRL=0x3, then read at 0x00. Required: prdata=0x3 after the setup phase and pready=penable. A write to 0x08 leaves BCLK_PF unchanged.
